// File: rtl/io_tx_bridge.sv
// io_tx_bridge: cpu-bus I/O decode (0x3xxxx), TX byte FIFO, rx/cycle-counter reads, halt.
// Ports: clk_in/rst_in, cpu bus (rdy_in, mem_a, mem_dout, mem_wr), io_dout/io_sel/io_buffer_full,
// tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_pop, halt, dbg_drop_cnt (IO_DROP_STAT_EN).
module io_tx_bridge #(
  parameter int DEPTH_LOG2  = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  io_dout,
  output logic        io_sel,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt,
  output logic [7:0]  dbg_drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_TH = PW'(DEPTH - FULL_MARGIN);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wp, rp, count, count_nxt;
  logic [31:0]   cycle_cnt;
  logic          halt_pend;
  logic          io_acc, a_data, wr_data, wr_ctrl;
  logic          rd_data, rd_cnt;
  logic          push_req, push_ok, pop, full;
  logic [7:0]    push_byte, rd_byte;
  logic          unused_addr;

  assign unused_addr = ^mem_a[31:18];

  assign io_acc  = rdy_in & (mem_a[17:16] == 2'b11);
  assign a_data  = mem_a[15:0] == 16'h0000;
  assign wr_data = io_acc & mem_wr & a_data
                 & (mem_dout != 8'h00);
  assign wr_ctrl = io_acc & mem_wr
                 & (mem_a[15:0] == 16'h0004);
  assign rd_data = io_acc & ~mem_wr & a_data;
  assign rd_cnt  = io_acc & ~mem_wr
                 & (mem_a[15:2] == 14'h0001);

  assign push_req  = wr_data | wr_ctrl;
  assign push_byte = wr_ctrl ? 8'h00 : mem_dout;

  assign count    = wp - rp;
  assign full     = count == DEPTH_C;
  assign tx_valid = wp != rp;
  assign tx_data  = mem[rp[DEPTH_LOG2-1:0]];
  assign pop      = tx_valid & tx_ready;

  // a full FIFO still takes a byte when the head leaves in the same cycle
  assign push_ok   = push_req & ~halt_pend & (~full | pop);
  assign count_nxt = count + PW'(push_ok) - PW'(pop);

  assign rx_pop = rd_data & rx_valid;

  always_comb begin
    rd_byte = 8'h00;
    unique case (1'b1)
      rd_data: rd_byte = rx_valid ? rx_data : 8'h00;
      rd_cnt:  rd_byte = cycle_cnt[{mem_a[1:0], 3'b000} +: 8];
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wp             <= '0;
      rp             <= '0;
      cycle_cnt      <= '0;
      halt_pend      <= 1'b0;
      halt           <= 1'b0;
      io_buffer_full <= 1'b0;
      io_dout        <= 8'h00;
      io_sel         <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (push_ok) wp <= wp + PW'(1);
      if (pop)     rp <= rp + PW'(1);
      if (push_ok & wr_ctrl) halt_pend <= 1'b1;
      // only the sentinel can be a zero byte in the FIFO
      if (pop & (tx_data == 8'h00)) halt <= 1'b1;
      io_buffer_full <= count_nxt >= FULL_TH;
      io_sel <= io_acc;
      if (io_acc & ~mem_wr) io_dout <= rd_byte;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (push_ok) begin
      mem[wp[DEPTH_LOG2-1:0]] <= push_byte;
    end
  end

`ifdef IO_DROP_STAT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      drop_q <= 8'h00;
    end else if (push_req & ~push_ok
                 & (push_byte != 8'h00)
                 & (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign dbg_drop_cnt = drop_q;
`else
  assign dbg_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_io_tx_bridge.sv
// tb_io_tx_bridge: directed steps with a TX scoreboard queue for io_tx_bridge.
// Expected bytes are queued on stimulus and popped on each tx handshake.
module tb_io_tx_bridge;

`ifdef IO_DROP_STAT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  io_dout;
  logic        io_sel;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        halt;
  logic [7:0]  dbg_drop_cnt;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  q[$];
  bit          hp = 1'b0;
  int          exp_drop = 0;
  logic [31:0] tb_cyc;

  io_tx_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .io_dout(io_dout), .io_sel(io_sel),
    .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .halt(halt), .dbg_drop_cnt(dbg_drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) tb_cyc <= '0;
    else tb_cyc <= tb_cyc + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [17:0] a, input logic [7:0] d);
    logic [7:0] pd;
    bit acc;
    rdy_in = 1'b1; mem_a = {14'h0, a}; mem_dout = d; mem_wr = 1'b1;
    if ((a == 18'h30000 && d != 8'h00) || a == 18'h30004) begin
      pd = (a == 18'h30004) ? 8'h00 : d;
      acc = !hp && (q.size() < 8 || tx_ready);
      if (acc) begin
        q.push_back(pd);
        if (a == 18'h30004) hp = 1'b1;
      end else if (pd != 8'h00 && exp_drop < 255) begin
        exp_drop++;
      end
    end
    step();
    mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
  endtask

  task automatic rd(input logic [17:0] a, input logic [7:0] exp,
                    input logic exp_pop, input string tag);
    rdy_in = 1'b1; mem_a = {14'h0, a}; mem_wr = 1'b0;
    #1;
    chk({tag, "_pop"}, rx_pop, exp_pop);
    step();
    mem_a = '0;
    chk(tag, io_dout, exp);
    chk({tag, "_sel"}, io_sel, 1);
  endtask

  // scoreboard: each handshake consumes the oldest expected byte
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL tx_extra got=%0h exp=none", tx_data);
      end
      if (q.size() != 0) begin
        automatic logic [7:0] e = q.pop_front();
        chk("tx_data", tx_data, e);
        if (e == 8'h00) begin
          chk("halt_pre", halt, 0);
          @(negedge clk_in);
          chk("halt_post", halt, 1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_full", io_buffer_full, 0);
    chk("rst_io_dout", io_dout, 0);
    chk("rst_io_sel", io_sel, 0);
    chk("rst_drop", dbg_drop_cnt, 0);
    #10 rst_in = 1'b1;
    step();

    // three bytes streamed out with tx_ready high
    tx_ready = 1'b1;
    wr(18'h30000, 8'h41);
    chk("t1_valid_t1", tx_valid, 1);
    chk("t1_sel", io_sel, 1);
    wr(18'h30000, 8'h42);
    wr(18'h30000, 8'h43);
    step(); step();
    chk("t1_drained", q.size(), 0);
    chk("t1_idle_valid", tx_valid, 0);
    chk("idle_sel", io_sel, 0);

    // zero byte to the data port is ignored
    wr(18'h30000, 8'h00);
    chk("t2_valid", tx_valid, 0);
    chk("t2_sel", io_sel, 1);

    // bus frozen when rdy_in is low
    rdy_in = 1'b0; mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h5A;
    step();
    mem_a = '0; mem_wr = 1'b0; rdy_in = 1'b1;
    chk("rdy0_valid", tx_valid, 0);
    chk("rdy0_sel", io_sel, 0);

    // rx reads
    rx_valid = 1'b0; rx_data = 8'h77;
    rd(18'h30000, 8'h00, 1'b0, "rx_empty");
    rx_valid = 1'b1; rx_data = 8'hA5;
    rd(18'h30000, 8'hA5, 1'b1, "rx_data");
    rx_valid = 1'b0;

    // cycle counter reads starting at cycle 100
    for (int i = 0; i < 200 && tb_cyc < 100; i++) step();
    chk("cyc_at_100", tb_cyc, 100);
    for (int k = 0; k < 4; k++) begin
      automatic logic [31:0] c = tb_cyc;
      rd(18'h30004 + 18'(k), c[8*k +: 8], 1'b0, $sformatf("cnt%0d", k));
    end

    // fill with tx_ready low: full flag at 6, drops past 8
    tx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wr(18'h30000, 8'h60 + 8'(i));
      if (i == 5) chk("full_at5", io_buffer_full, 0);
      if (i == 6) chk("full_at6", io_buffer_full, 1);
    end
    chk("fill_q", q.size(), 8);
    chk("fill_drop", dbg_drop_cnt, DROP_EN ? exp_drop : 0);
    // push into full FIFO while head leaves the same cycle
    tx_ready = 1'b1;
    wr(18'h30000, 8'h7E);
    chk("full_pop_push_full", io_buffer_full, 1);
    chk("full_pop_push_drop", dbg_drop_cnt, DROP_EN ? exp_drop : 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain_q", q.size(), 0);
    step();
    chk("drain_valid", tx_valid, 0);
    chk("drain_full", io_buffer_full, 0);

    // halt sequence
    wr(18'h30000, 8'h58);
    wr(18'h30004, 8'h00);
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("halt_drain", q.size(), 0);
    step(); step();
    chk("halt_set", halt, 1);
    wr(18'h30000, 8'h51);
    chk("post_halt_valid", tx_valid, 0);
    chk("post_halt_drop", dbg_drop_cnt, DROP_EN ? exp_drop : 0);
    step();
    chk("halt_sticky", halt, 1);

    // asynchronous reset with bytes queued
    tx_ready = 1'b0;
    rst_in = 1'b0; #2; rst_in = 1'b1;
    q.delete(); hp = 1'b0; exp_drop = 0;
    step();
    wr(18'h30000, 8'h11);
    wr(18'h30000, 8'h22);
    chk("pre_rst_valid", tx_valid, 1);
    #3 rst_in = 1'b0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_halt", halt, 0);
    chk("arst_drop", dbg_drop_cnt, 0);
    q.delete(); hp = 1'b0; exp_drop = 0;
    @(negedge clk_in) rst_in = 1'b1;
    step(); step();
    chk("post_rst_valid", tx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
